uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the Simple MPU: it recovers 8N1 serial frames from the PC on the serial line and delivers each byte to the ALU datapath as a one-cycle-valid parallel word. It is the receive-side counterpart of the UART transmit path and uses the same bit-period timing. It contains the input synchronizer, start-bit validation, mid-bit sampling, framing check and output register.

## Interface
- CLKS_PER_BIT, default 5208, is the number of clk cycles per bit (50 MHz / 9600 baud). Legal values are 4 and above.
- clk  input  1  is the system clock. The block uses one clock, and all logic is on the rising edge.
- rst  input  1  is the reset. It is synchronous and active-high.
- i_rx  input  1  is the asynchronous serial line. It idles high.
- o_rx_d  output  8  is the last correctly framed byte. It holds its value until the next good frame.
- o_rx_valid  output  1  pulses for one cycle when o_rx_d is updated.
- o_rx_err  output  1  pulses for one cycle on a framing error (stop bit sampled low).
- o_rx_busy  output  1  is high from the start-bit detect until the frame ends.

## Operation
- **Synchronizer.** Two flops on i_rx produce rx_s, plus one more flop for rx_s_prev. All three reset to 1, so no false start can occur after reset.
- **Bit counter.** A bit-period counter of width $clog2(CLKS_PER_BIT) clears on every state entry and counts up each cycle. A bit index of 0..7 tracks the data bits. A shift register assembles data LSB-first.
- **State machine:**
  - IDLE: busy=0. When rx_s_prev=1 and rx_s=0 (falling edge), go to START and clear the counter. A low level alone never starts a frame.
  - START: at count == CLKS_PER_BIT/2 − 1, sample rx_s.
    - If 0, go to DATA and clear the counter and index.
    - If 1, treat it as a glitch and return to IDLE with no pulses.
  - DATA: at count == CLKS_PER_BIT − 1, sample rx_s into bit[index] and clear the counter.
    - After index 7, go to STOP. Otherwise increment the index.
  - STOP: at count == CLKS_PER_BIT − 1, sample rx_s and go to IDLE.
    - If 1, load o_rx_d from the shift register and pulse o_rx_valid.
    - If 0, pulse o_rx_err and leave o_rx_d unchanged.
- **Break line.** After a framing error with the line held low, IDLE waits for a high followed by a falling edge before starting again.
- **Pulses.** o_rx_valid and o_rx_err are never high in the same cycle. Neither is ever high for more than one cycle.
- **Reset.** rst has priority over everything, including mid-frame. It returns the block to IDLE, clears the counter, index and shift register, and sets all outputs to 0.

## Timing
- **Reset values:** o_rx_d=8'h00, o_rx_valid=0, o_rx_err=0, o_rx_busy=0.
- **Synchronizer latency:** 2 cycles from the i_rx pin to rx_s.
- **Sample points:** relative to the start-detect cycle (cycle 0, IDLE→START):
  - start sample at CLKS_PER_BIT/2;
  - data bit k sample at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop sample at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
  - With CLKS_PER_BIT=16, the stop sample is at cycle 152.
- **Result timing:** o_rx_valid/o_rx_err is registered, so it is high in the cycle after the stop sample. o_rx_busy falls in that same cycle.
- **Back-to-back frames:** the block returns to IDLE half a bit before the nominal stop-bit end. This means a following start edge with zero idle time is always caught.

## Structure
- A shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP);
  - DATA_BITS = 8;
  - the default CLKS_PER_BIT, shared with the transmit path.
- Sub-module rx_bps_counter is the bit-period counter. Its interface is clr and en in, and half_tick and full_tick out. It mirrors the transmit-side baud counter.
- The top level uart_rx holds the synchronizer, the state machine, the shift register and the output registers.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **Reset and idle:** apply rst for 3 cycles with i_rx=1, then idle for 300 cycles → all outputs stay 0, with no pulses.
- **Good frame:** send 8'hA5 as 8N1 → exactly one o_rx_valid pulse at cycle 153 after start detect, with o_rx_d=8'hA5 and o_rx_err=0. o_rx_busy is high across cycles 1–152.
- **Glitch:** drive i_rx low for 4 cycles, then high → o_rx_busy pulses for the START check only. There is no valid or err pulse, and the next frame 8'h3C is received correctly.
- **Framing error and break:** send 8'h3C with a low stop bit, then hold i_rx low for 100 cycles → one o_rx_err pulse and o_rx_d stays 8'hA5. No further activity occurs until the line returns high and a new frame 8'h81 arrives, which is received correctly.
- **Back-to-back:** send 8'h00 then 8'hFF with no idle bits between them → two valid pulses, carrying 8'h00 and then 8'hFF, and no err.
- **Reset mid-frame:** assert rst during data bit 4 → outputs are 0 in the next cycle. The following frame 8'h5A is received correctly with a single valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and default bit timing.
// The transmit path uses the same default bit period.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/rx_bps_counter.sv
// Receive bit-period counter: free-runs while enabled and flags the half-bit and full-bit points.
// It has the same structure as the transmit-side baud counter.
module rx_bps_counter #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_half_tick,
    output logic o_full_tick
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_half_tick = (r_cnt == HalfLast);
    assign o_full_tick = (r_cnt == FullLast);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, validates the start bit and samples each bit
// mid-period. Good frames produce a one-cycle valid pulse; a low stop bit produces an error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_d,
    output logic                 o_rx_valid,
    output logic                 o_rx_err,
    output logic                 o_rx_busy
);

    localparam int unsigned     IdxW    = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    rx_state_e            r_state;
    rx_state_e            w_state_next;
    logic [IdxW-1:0]      r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_d;
    logic                 r_rx_valid;
    logic                 r_rx_err;

    logic w_half_tick;
    logic w_full_tick;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_busy;
    logic w_start_ok;
    logic w_sample_bit;
    logic w_stop_sample;

    // Synchronizer flops reset high so an idle line never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    rx_bps_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bps_counter (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_cnt_clr),
        .i_en        (w_cnt_en),
        .o_half_tick (w_half_tick),
        .o_full_tick (w_full_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                // Edge-triggered start: a line held low after a break cannot restart a frame.
                if (r_rx_prev && !r_rx_s) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (w_half_tick) begin
                    w_state_next = r_rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (w_full_tick && (r_idx == IdxLast)) begin
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_full_tick) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        w_busy        = (r_state != StIdle);
        w_cnt_en      = w_busy;
        w_start_ok    = (r_state == StStart) && (w_state_next == StData);
        w_sample_bit  = (r_state == StData) && w_full_tick;
        w_stop_sample = (r_state == StStop) && w_full_tick;
        w_cnt_clr     = (w_state_next != r_state) || w_sample_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_shift    <= '0;
            r_rx_d     <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            if (w_start_ok) begin
                r_idx <= '0;
            end
            if (w_sample_bit) begin
                r_shift[r_idx] <= r_rx_s;
                r_idx          <= r_idx + 1'b1;
            end
            if (w_stop_sample) begin
                if (r_rx_s) begin
                    r_rx_d     <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_err   <= 1'b1;
                end
            end
        end
    end

    assign o_rx_d     = r_rx_d;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_err   = r_rx_err;
    assign o_rx_busy  = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: a scoreboard queue holds the expected
// pulse for every frame sent and a negedge monitor pops and compares on each valid/err pulse.
module tb_uart_rx;

    localparam int unsigned C = 16;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_rx;
    logic [7:0] o_rx_d;
    logic       o_rx_valid;
    logic       o_rx_err;
    logic       o_rx_busy;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         busy_cycles = 0;
    int         busy_rise_cyc = 0;
    int         pulse_cyc = 0;
    int         fall_cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_busy = 1'b0;
    logic       prev_pulse = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (i_rx),
        .o_rx_d     (o_rx_d),
        .o_rx_valid (o_rx_valid),
        .o_rx_err   (o_rx_err),
        .o_rx_busy  (o_rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_busy  = 1'b0;
            prev_pulse = 1'b0;
            last_good  = 8'h00;
        end else begin
            if (o_rx_busy) busy_cycles++;
            if (o_rx_busy && !prev_busy) busy_rise_cyc = cyc;
            prev_busy = o_rx_busy;
            if (o_rx_valid || o_rx_err) begin
                pulse_cyc = cyc;
                if (o_rx_valid) n_valid++;
                if (o_rx_err) n_err++;
                checks++;
                if (o_rx_valid && o_rx_err) begin
                    errors++;
                    $display("FAIL pulse_exclusive: valid=%b err=%b, required one only",
                             o_rx_valid, o_rx_err);
                end
                checks++;
                if (prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_width: pulse high in consecutive cycles at cyc %0d", cyc);
                end
                checks++;
                if (o_rx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_pulse: busy=%b, required 0", o_rx_busy);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%b err=%b d=%h, none expected",
                             o_rx_valid, o_rx_err, o_rx_d);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (o_rx_err !== e.is_err) begin
                        errors++;
                        $display("FAIL pulse_kind: err=%b, required %b", o_rx_err, e.is_err);
                    end
                    checks++;
                    if (o_rx_d !== (e.is_err ? last_good : e.data)) begin
                        errors++;
                        $display("FAIL rx_data: got %h, required %h", o_rx_d,
                                 e.is_err ? last_good : e.data);
                    end
                    if (!e.is_err) last_good = e.data;
                end
            end
            prev_pulse = o_rx_valid || o_rx_err;
        end
    end

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Leaves the line at the stop-bit level so frames can be chained with no idle time.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        i_rx     = 1'b0;
        fall_cyc = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            repeat (C) @(negedge clk);
        end
        i_rx = stop;
        repeat (C) @(negedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        int v0, e0, b0;
        rst  = 1'b1;
        i_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_rx_d, o_rx_valid, o_rx_err, o_rx_busy} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: d=%h v=%b e=%b b=%b, required all 0",
                     o_rx_d, o_rx_valid, o_rx_err, o_rx_busy);
        end
        rst = 1'b0;
        v0 = n_valid; e0 = n_err; b0 = busy_cycles;
        idle(300);
        check_int("idle_valid", n_valid - v0, 0);
        check_int("idle_err", n_err - e0, 0);
        check_int("idle_busy", busy_cycles - b0, 0);
        checks++;
        if (o_rx_d !== 8'h00) begin
            errors++;
            $display("FAIL idle_data: got %h, required 00", o_rx_d);
        end
    endtask

    task automatic test_good_frame;
        int v0, e0, b0;
        exp_q.push_back('{is_err: 1'b0, data: 8'h37});
        send_frame(8'h37, 1'b1);
        idle(2 * C);
        v0 = n_valid; e0 = n_err; b0 = busy_cycles;
        exp_q.push_back('{is_err: 1'b0, data: 8'hA5});
        send_frame(8'hA5, 1'b1);
        idle(2 * C);
        check_int("start_detect_latency", busy_rise_cyc - fall_cyc, 3);
        check_int("valid_cycle", pulse_cyc - busy_rise_cyc, 152);
        check_int("busy_span", busy_cycles - b0, 152);
        check_int("good_valid_count", n_valid - v0, 1);
        check_int("good_err_count", n_err - e0, 0);
        check_int("good_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_frame_error;
        int v0, e0, b0;
        v0 = n_valid; e0 = n_err;
        exp_q.push_back('{is_err: 1'b1, data: 8'h3C});
        send_frame(8'h3C, 1'b0);
        b0 = busy_cycles;
        i_rx = 1'b0;
        repeat (100) @(negedge clk);
        check_int("ferr_err_count", n_err - e0, 1);
        check_int("ferr_valid_count", n_valid - v0, 0);
        check_int("break_busy", busy_cycles - b0, 0);
        checks++;
        if (o_rx_d !== 8'hA5) begin
            errors++;
            $display("FAIL ferr_data_held: got %h, required a5", o_rx_d);
        end
        idle(2 * C);
        v0 = n_valid;
        exp_q.push_back('{is_err: 1'b0, data: 8'h81});
        send_frame(8'h81, 1'b1);
        idle(2 * C);
        check_int("after_break_valid", n_valid - v0, 1);
        check_int("after_break_queue", exp_q.size(), 0);
    endtask

    task automatic test_glitch;
        int v0, e0, b0;
        v0 = n_valid; e0 = n_err; b0 = busy_cycles;
        i_rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(2 * C);
        check_int("glitch_busy", busy_cycles - b0, C / 2);
        check_int("glitch_valid", n_valid - v0, 0);
        check_int("glitch_err", n_err - e0, 0);
        exp_q.push_back('{is_err: 1'b0, data: 8'h3C});
        send_frame(8'h3C, 1'b1);
        idle(2 * C);
        check_int("post_glitch_valid", n_valid - v0, 1);
        check_int("post_glitch_queue", exp_q.size(), 0);
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        exp_q.push_back('{is_err: 1'b0, data: 8'h00});
        exp_q.push_back('{is_err: 1'b0, data: 8'hFF});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2 * C);
        check_int("b2b_valid", n_valid - v0, 2);
        check_int("b2b_err", n_err - e0, 0);
        check_int("b2b_queue", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        int         v0, e0;
        d    = 8'hC3;
        i_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i_rx = d[i];
            repeat (C) @(negedge clk);
        end
        i_rx = d[4];
        repeat (C / 2) @(negedge clk);
        rst  = 1'b1;
        i_rx = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_rx_d, o_rx_valid, o_rx_err, o_rx_busy} !== 11'h000) begin
            errors++;
            $display("FAIL midframe_reset: d=%h v=%b e=%b b=%b, required all 0",
                     o_rx_d, o_rx_valid, o_rx_err, o_rx_busy);
        end
        rst = 1'b0;
        v0 = n_valid; e0 = n_err;
        idle(12 * C);
        check_int("post_reset_quiet", (n_valid - v0) + (n_err - e0), 0);
        exp_q.push_back('{is_err: 1'b0, data: 8'h5A});
        send_frame(8'h5A, 1'b1);
        idle(2 * C);
        check_int("post_reset_valid", n_valid - v0, 1);
        check_int("post_reset_err", n_err - e0, 0);
        check_int("post_reset_queue", exp_q.size(), 0);
        checks++;
        if (o_rx_d !== 8'h5A) begin
            errors++;
            $display("FAIL post_reset_data: got %h, required 5a", o_rx_d);
        end
    endtask

    initial begin
        rst  = 1'b1;
        i_rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
